mem_bus_responder: RTL



---
 rtl/mem_bus_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory-side responder for the 64-bit tagged system bus. Serves one
//   request at a time: a line read returns 8 beats critical-word-first with
//   wrap inside the 64-byte line; a line write absorbs 8 data beats into the
//   internal word memory. A backdoor port lets a testbench or boot loader
//   preload words in any state.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset (control state only, memory kept)
//   bus_reqcyc   request valid (header cycle, then write data beats)
//   bus_req      byte address on the header cycle, write data on data beats
//   bus_reqtag   request tag: [12] targets memory, [11:8] command
//   bus_reqack   header or write beat accepted (registered, one cycle later)
//   bus_respcyc  response beat valid
//   bus_respack  initiator consumed the current response beat
//   bus_resp     response data
//   bus_resptag  tag of the accepted request
//   init_we      backdoor word write enable
//   init_addr    backdoor byte address
//   init_data    backdoor write data
module mem_bus_responder #(
  parameter int         BUS_TAG_WIDTH  = 13,
  parameter int         BUS_DATA_WIDTH = 64,
  parameter int         MEM_WORDS      = 4096,
  parameter int         LATENCY        = 4,
  parameter logic [3:0] READ_CMD       = 4'h1,
  parameter logic [3:0] WRITE_CMD      = 4'h3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      init_we,
  input  logic [63:0]               init_addr,
  input  logic [BUS_DATA_WIDTH-1:0] init_data
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam int         LW       = AW - 3;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, LAT, RESP, WDATA} state_t;

  state_t                    state;
  logic [LW-1:0]             line_base;
  logic [2:0]                start_beat;
  logic [2:0]                beat;
  logic [3:0]                lat_cnt;
  logic                      wr_hdr;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [3:0]    req_cmd;
  logic          req_is_read;
  logic          req_is_write;
  logic          wr_beat;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] init_idx;
  logic          unused_init_bits;

  // Word index of beat n of the current line: offset wraps within the line.
  function automatic logic [AW-1:0] word_idx(input logic [LW-1:0] base,
                                             input logic [2:0]    start,
                                             input logic [2:0]    n);
    logic [2:0] off;
    off = start + n;
    return {base, off};
  endfunction

  assign req_cmd      = bus_reqtag[BUS_TAG_WIDTH-2 -: 4];
  assign req_is_read  = bus_reqcyc && bus_reqtag[BUS_TAG_WIDTH-1] && (req_cmd == READ_CMD);
  assign req_is_write = bus_reqcyc && bus_reqtag[BUS_TAG_WIDTH-1] && (req_cmd == WRITE_CMD);

  // The header is still on the bus during the ack cycle, so that cycle is
  // never taken as a data beat.
  assign wr_beat  = (state == WDATA) && !wr_hdr && bus_reqcyc;
  assign wr_idx   = word_idx(line_base, start_beat, beat);
  assign init_idx = init_addr[3 +: AW];

  // Upper address bits alias; byte offset within a word is meaningless.
  assign unused_init_bits = ^{init_addr[63:3+AW], init_addr[2:0]};

  // Backdoor is issued last so it wins a same-word collision with the bus.
  always_ff @(posedge clk) begin
    if (wr_beat && !reset) begin
      mem[wr_idx] <= bus_req;
    end
    if (init_we) begin
      mem[init_idx] <= init_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      beat        <= 3'd0;
      lat_cnt     <= 4'd0;
      wr_hdr      <= 1'b0;
    end else begin
      bus_reqack <= 1'b0;
      wr_hdr     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_is_read || req_is_write) begin
            line_base   <= bus_req[6 +: LW];
            start_beat  <= bus_req[5:3];
            bus_resptag <= bus_reqtag;
            bus_reqack  <= 1'b1;
            beat        <= 3'd0;
            if (req_is_read) begin
              state   <= LAT;
              lat_cnt <= LAT_LOAD;
            end else begin
              state  <= WDATA;
              wr_hdr <= 1'b1;
            end
          end
        end
        // Synchronous read: the first word is fetched on the same edge
        // that raises respcyc.
        LAT: begin
          if (lat_cnt == 4'd0) begin
            state       <= RESP;
            bus_respcyc <= 1'b1;
            bus_resp    <= mem[word_idx(line_base, start_beat, 3'd0)];
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        // Each acked beat fetches the next word in the same edge, so acked
        // beats stream without bubbles; no ack holds beat and data.
        RESP: begin
          if (bus_respack) begin
            if (beat == 3'd7) begin
              state       <= IDLE;
              bus_respcyc <= 1'b0;
              bus_resp    <= '0;
              beat        <= 3'd0;
            end else begin
              beat     <= beat + 3'd1;
              bus_resp <= mem[word_idx(line_base, start_beat, beat + 3'd1)];
            end
          end
        end
        WDATA: begin
          if (wr_beat) begin
            bus_reqack <= 1'b1;
            beat       <= beat + 3'd1;
            if (beat == 3'd7) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
